rf_wb_arbiter: RTL

//  Shares the single register-file write port between the core's same-cycle writeback (primary)
//  and results returned late by long-latency units (mult/div, load return).

---
 rtl/rf_wb_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Purpose: shares the register-file write port between the primary writeback and buffered late results, and tracks pending destinations.
// Latency: a primary write reaches the rf port in the same cycle; an accepted late result is writable 1 cycle after accept, with no bypass.
// Backpressure: l_ready drops while the buffer is full; the head starves at most STARVE_MAX cycles, and then stall_cpu pre-empts the primary.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   p_we/p_waddr/p_wdata       primary same-cycle write (no handshake)
//   l_valid/l_waddr/l_wdata    late result in; l_ready accepts it
//   sb_set/sb_addr             mark a long-op destination pending
//   chk_addr1/2, hazard        decode source check against pending set
//   stall_cpu                  core holds; its p_we is ignored this cycle
//   rf_w/rf_waddr/rf_wdata     regfile write port
//   fifo_cnt                   late-result buffer occupancy

// Generic in-order buffer. A push is refused when full, even if a pop frees a slot in the same cycle.
module rf_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_vld,
    output logic [W-1:0]     head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; the occupancy count qualifies every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        p_we,
    input  logic [ADDR_W-1:0]           p_waddr,
    input  logic [DATA_W-1:0]           p_wdata,
    input  logic                        l_valid,
    input  logic [ADDR_W-1:0]           l_waddr,
    input  logic [DATA_W-1:0]           l_wdata,
    output logic                        l_ready,
    input  logic                        sb_set,
    input  logic [ADDR_W-1:0]           sb_addr,
    input  logic [ADDR_W-1:0]           chk_addr1,
    input  logic [ADDR_W-1:0]           chk_addr2,
    output logic                        hazard,
    output logic                        stall_cpu,
    output logic                        rf_w,
    output logic [ADDR_W-1:0]           rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam int NREG  = 2 ** ADDR_W;
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } late_ent_t;

    late_ent_t         push_dat;
    late_ent_t         head_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_vld;
    logic              pop_vld;
    logic [SC_W-1:0]   starve_cnt;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic              grant_vld;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    assign push_dat = '{addr: l_waddr, data: l_wdata};
    assign l_ready  = !fifo_full;
    assign push_vld = l_valid && !fifo_full;

    rf_wb_fifo #(
        .W     ($bits(late_ent_t)),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_late_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt)
    );

    // The head has lost the port STARVE_MAX times in a row, so it now pre-empts the primary.
    assign stall_cpu = (starve_cnt == STARVE_LIM) && !fifo_empty;

    always_comb begin
        pop_vld    = 1'b0;
        grant_vld  = 1'b0;
        grant_addr = '0;
        grant_data = '0;
        if (stall_cpu) begin
            pop_vld    = 1'b1;
            grant_vld  = 1'b1;
            grant_addr = head_dat.addr;
            grant_data = head_dat.data;
        end else if (p_we) begin
            grant_vld  = 1'b1;
            grant_addr = p_waddr;
            grant_data = p_wdata;
        end else if (!fifo_empty) begin
            pop_vld    = 1'b1;
            grant_vld  = 1'b1;
            grant_addr = head_dat.addr;
            grant_data = head_dat.data;
        end
    end

    // An entry popped for r0 still retires; it simply never reaches the regfile.
    assign rf_w     = grant_vld && (grant_addr != '0) && !reset;
    assign rf_waddr = grant_addr;
    assign rf_wdata = grant_data;

    // A non-empty buffer with no pop means the primary took the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop_vld) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // The set is applied after the clear, so a newly issued op wins over the retiring one.
    always_comb begin
        pending_nxt = pending;
        if (pop_vld) begin
            pending_nxt[head_dat.addr] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            pending_nxt[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign hazard = ((chk_addr1 != '0) && pending[chk_addr1]) ||
                    ((chk_addr2 != '0) && pending[chk_addr2]);
endmodule
